// File: rtl/epu_sram_pkg.sv
// epu_sram_pkg: shared types for the EPU SRAM arbiter.
// Row geometry, arbiter states and the client request bundle.
package epu_sram_pkg;

  localparam int EPU_SRAM_ADDR_W = 12;
  localparam int EPU_SRAM_DATA_W = 128;
  localparam int EPU_SRAM_LANES  = 4;

  typedef enum logic [1:0] {
    FREE,
    LOCK0,
    LOCK1
  } arb_state_e;

  typedef struct packed {
    logic [EPU_SRAM_LANES-1:0]  we;
    logic [EPU_SRAM_ADDR_W-1:0] addr;
    logic [EPU_SRAM_DATA_W-1:0] wdata;
    logic                       lock;
  } client_req_t;

  function automatic logic is_read(
    input logic [EPU_SRAM_LANES-1:0] we
  );
    return ~|we;
  endfunction

endpackage

// File: rtl/epu_arb_wait_ctr.sv
// epu_arb_wait_ctr: per-client saturating wait counter.
// Flags a client that has been refused for MAX_WAIT cycles.
module epu_arb_wait_ctr #(
  parameter int MAX_WAIT = 8
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic req,
  input  logic gnt,
  output logic starving
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_WAIT);

  logic [CW-1:0] cnt_q;

  // count refused request cycles, clear on grant or idle
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q <= '0;
    end else if (!req || gnt) begin
      cnt_q <= '0;
    end else if (cnt_q != CMAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign starving = (cnt_q == CMAX);

endmodule

// File: rtl/epu_sram_arbiter.sv
// epu_sram_arbiter: shares the 128-bit EPU SRAM between the
// AXI/DMA client (c0) and the EPU engine (c1), with burst locking.
module epu_sram_arbiter
  import epu_sram_pkg::*;
#(
  parameter int ADDR_W   = EPU_SRAM_ADDR_W,
  parameter int DATA_W   = EPU_SRAM_DATA_W,
  parameter int LANES    = EPU_SRAM_LANES,
  parameter int MAX_WAIT = 8,
  parameter int LOCK_MAX = 16
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              c0_req,
  input  logic [LANES-1:0]  c0_we,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  input  logic              c0_lock,
  output logic              c0_gnt,
  output logic              c0_rvalid,
  output logic [DATA_W-1:0] c0_rdata,
  input  logic              c1_req,
  input  logic [LANES-1:0]  c1_we,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  input  logic              c1_lock,
  output logic              c1_gnt,
  output logic              c1_rvalid,
  output logic [DATA_W-1:0] c1_rdata,
  output logic [LANES-1:0]  SRAM_WEB,
  output logic [ADDR_W-1:0] SRAM_A,
  output logic [DATA_W-1:0] SRAM_DI,
  input  logic [DATA_W-1:0] SRAM_DO
);

  localparam int LCW = $clog2(LOCK_MAX + 1);
  localparam logic [LCW-1:0] LAST = LCW'(LOCK_MAX - 1);
  localparam logic [LCW-1:0] LFULL = LCW'(LOCK_MAX);
  localparam bit CAN_LOCK = (LOCK_MAX > 1);

  client_req_t r0;
  client_req_t r1;
  client_req_t sel;
  arb_state_e  state_q;
  arb_state_e  state_d;
  logic [LCW-1:0] lock_cnt_q;
  logic starve0;
  logic starve1;
  logic any_gnt;
  logic lock_last;
  logic rv0_q;
  logic rv1_q;

  assign r0 = '{we: c0_we, addr: c0_addr,
                wdata: c0_wdata, lock: c0_lock};
  assign r1 = '{we: c1_we, addr: c1_addr,
                wdata: c1_wdata, lock: c1_lock};

  epu_arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait0 (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .req      (c0_req),
    .gnt      (c0_gnt),
    .starving (starve0)
  );

  epu_arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait1 (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .req      (c1_req),
    .gnt      (c1_gnt),
    .starving (starve1)
  );

  assign any_gnt   = c0_gnt | c1_gnt;
  assign lock_last = (lock_cnt_q >= LAST);

  // arbiter state register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= FREE;
    end else begin
      state_q <= state_d;
    end
  end

  // lock entry, release on unlock, burst limit or abandon
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FREE: begin
        if (any_gnt && sel.lock && CAN_LOCK) begin
          state_d = c0_gnt ? LOCK0 : LOCK1;
        end
      end
      LOCK0: begin
        if (c0_gnt) begin
          if (!sel.lock || lock_last) state_d = FREE;
        end else if (!c0_req && !r0.lock) begin
          state_d = FREE;
        end
      end
      LOCK1: begin
        if (c1_gnt) begin
          if (!sel.lock || lock_last) state_d = FREE;
        end else if (!c1_req && !r1.lock) begin
          state_d = FREE;
        end
      end
      default: state_d = FREE;
    endcase
  end

  // grants: starving c0 beats c1, c1 beats c0, owner only when locked
  always_comb begin
    c0_gnt = 1'b0;
    c1_gnt = 1'b0;
    if (RSTn) begin
      unique case (state_q)
        FREE: begin
          c0_gnt = c0_req &&
                   (!c1_req || (starve0 && !starve1));
          c1_gnt = c1_req && !c0_gnt;
        end
        LOCK0:   c0_gnt = c0_req;
        LOCK1:   c1_gnt = c1_req;
        default: ;
      endcase
    end
  end

  // locked-burst length, saturating
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      lock_cnt_q <= '0;
    end else if (state_d == FREE) begin
      lock_cnt_q <= '0;
    end else if (state_q == FREE) begin
      lock_cnt_q <= LCW'(1);
    end else if (any_gnt && lock_cnt_q != LFULL) begin
      lock_cnt_q <= lock_cnt_q + 1'b1;
    end
  end

  // route the granted client onto the SRAM bus
  always_comb begin
    sel = '0;
    unique case (1'b1)
      c0_gnt:  sel = r0;
      c1_gnt:  sel = r1;
      default: ;
    endcase
  end

  assign SRAM_WEB = ~sel.we;
  assign SRAM_A   = sel.addr;
  assign SRAM_DI  = sel.wdata;

  // read data returns one cycle after a read grant
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
    end else begin
      rv0_q <= c0_gnt && is_read(c0_we);
      rv1_q <= c1_gnt && is_read(c1_we);
    end
  end

  assign c0_rvalid = rv0_q;
  assign c1_rvalid = rv1_q;
  assign c0_rdata  = SRAM_DO;
  assign c1_rdata  = SRAM_DO;

endmodule

// File: tb/tb_epu_sram_arbiter.sv
// tb_epu_sram_arbiter: scoreboard bench for the EPU SRAM arbiter
// with a behavioural SRAM and a shadow copy of expected contents.
module tb_epu_sram_arbiter;

  localparam int AW = 12;
  localparam int DW = 128;
  localparam int LN = 4;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic          c0_req, c1_req;
  logic [LN-1:0] c0_we, c1_we;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [DW-1:0] c0_wdata, c1_wdata;
  logic          c0_lock, c1_lock;
  logic          c0_gnt, c1_gnt;
  logic          c0_rvalid, c1_rvalid;
  logic [DW-1:0] c0_rdata, c1_rdata;
  logic [LN-1:0] SRAM_WEB;
  logic [AW-1:0] SRAM_A;
  logic [DW-1:0] SRAM_DI;
  logic [DW-1:0] SRAM_DO;

  logic [DW-1:0] mem    [0:4095];
  logic [DW-1:0] shadow [0:4095];
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  epu_sram_arbiter dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .c0_req    (c0_req),
    .c0_we     (c0_we),
    .c0_addr   (c0_addr),
    .c0_wdata  (c0_wdata),
    .c0_lock   (c0_lock),
    .c0_gnt    (c0_gnt),
    .c0_rvalid (c0_rvalid),
    .c0_rdata  (c0_rdata),
    .c1_req    (c1_req),
    .c1_we     (c1_we),
    .c1_addr   (c1_addr),
    .c1_wdata  (c1_wdata),
    .c1_lock   (c1_lock),
    .c1_gnt    (c1_gnt),
    .c1_rvalid (c1_rvalid),
    .c1_rdata  (c1_rdata),
    .SRAM_WEB  (SRAM_WEB),
    .SRAM_A    (SRAM_A),
    .SRAM_DI   (SRAM_DI),
    .SRAM_DO   (SRAM_DO)
  );

  function automatic logic [DW-1:0] pat(input int a);
    return {32'hC3000000 ^ a, 32'h5A000000 ^ a,
            32'h0F000000 ^ a, 32'hF0000000 ^ a};
  endfunction

  // behavioural SRAM contents
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = pat(i);
    mem[16] = {4{32'hA5A5A5A5}};
  end

  // single-port SRAM, one-cycle read latency, lane writes
  always @(posedge CLK) begin
    for (int l = 0; l < LN; l++) begin
      if (!SRAM_WEB[l])
        mem[SRAM_A][32*l +: 32] <= SRAM_DI[32*l +: 32];
    end
    SRAM_DO <= mem[SRAM_A];
  end

  task automatic chk(input string tag,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // read-data scoreboard
  always @(negedge CLK) begin
    if (c0_rvalid === 1'b1) begin
      if (q0.size() == 0) chk("c0_rvalid_unexp", DW'(c0_rvalid), '0);
      else chk("c0_rdata", c0_rdata, q0.pop_front());
    end
    if (c1_rvalid === 1'b1) begin
      if (q1.size() == 0) chk("c1_rvalid_unexp", DW'(c1_rvalid), '0);
      else chk("c1_rdata", c1_rdata, q1.pop_front());
    end
  end

  task automatic drv0(input logic r, input logic [LN-1:0] w,
                      input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic l);
    c0_req = r; c0_we = w; c0_addr = a; c0_wdata = d; c0_lock = l;
  endtask

  task automatic drv1(input logic r, input logic [LN-1:0] w,
                      input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic l);
    c1_req = r; c1_we = w; c1_addr = a; c1_wdata = d; c1_lock = l;
  endtask

  task automatic wr_shadow(input logic [AW-1:0] a,
                           input logic [LN-1:0] w,
                           input logic [DW-1:0] d);
    for (int l = 0; l < LN; l++)
      if (w[l]) shadow[a][32*l +: 32] = d[32*l +: 32];
  endtask

  // check expected grants, log the access, advance one cycle
  task automatic step(input string tag, input logic g0, input logic g1);
    #1;
    chk({tag, "_g0"}, DW'(c0_gnt), DW'(g0));
    chk({tag, "_g1"}, DW'(c1_gnt), DW'(g1));
    if (g0) begin
      if (c0_we == '0) q0.push_back(shadow[c0_addr]);
      else wr_shadow(c0_addr, c0_we, c0_wdata);
    end
    if (g1) begin
      if (c1_we == '0) q1.push_back(shadow[c1_addr]);
      else wr_shadow(c1_addr, c1_we, c1_wdata);
    end
    @(negedge CLK);
  endtask

  initial begin
    logic [AW-1:0] a0, a1;
    logic g;
    int j;
    for (int i = 0; i < 4096; i++) shadow[i] = pat(i);
    shadow[16] = {4{32'hA5A5A5A5}};

    RSTn = 1'b0;
    drv0(1'b1, '0, 12'h055, '0, 1'b0);
    drv1(1'b1, '0, 12'h066, '0, 1'b0);
    #1;
    chk("rst_g0", DW'(c0_gnt), '0);
    chk("rst_g1", DW'(c1_gnt), '0);
    chk("rst_web", DW'(SRAM_WEB), DW'(4'hF));
    chk("rst_a", DW'(SRAM_A), '0);
    chk("rst_di", SRAM_DI, '0);
    chk("rst_rv", DW'({c0_rvalid, c1_rvalid}), '0);
    @(negedge CLK);
    @(negedge CLK);
    drv0(1'b0, '0, '0, '0, 1'b0);
    drv1(1'b0, '0, '0, '0, 1'b0);
    RSTn = 1'b1;
    @(negedge CLK);

    drv0(1'b1, '0, 12'h010, '0, 1'b0);
    #1;
    chk("t1_web", DW'(SRAM_WEB), DW'(4'hF));
    chk("t1_a", DW'(SRAM_A), DW'(12'h010));
    step("t1", 1'b1, 1'b0);
    drv0(1'b0, '0, '0, '0, 1'b0);
    #1;
    chk("t1_rv0", DW'(c0_rvalid), DW'(1'b1));
    chk("t1_rv1", DW'(c1_rvalid), '0);
    step("t1_idle", 1'b0, 1'b0);

    a0 = 12'h020;
    a1 = 12'h030;
    drv0(1'b1, '0, a0, '0, 1'b0);
    drv1(1'b1, '0, a1, '0, 1'b0);
    for (int k = 0; k < 27; k++) begin
      g = (k % 9 == 8);
      step($sformatf("t2_%0d", k), g, !g);
      if (g) begin a0++; c0_addr = a0; end
      else begin a1++; c1_addr = a1; end
    end
    drv0(1'b0, '0, '0, '0, 1'b0);
    drv1(1'b0, '0, '0, '0, 1'b0);
    step("t2_end", 1'b0, 1'b0);

    drv0(1'b1, 4'b0100, 12'h003,
         {32'h33333333, 32'hDEADBEEF, 32'h11111111, 32'h0}, 1'b0);
    #1;
    chk("t3_web", DW'(SRAM_WEB), DW'(4'b1011));
    chk("t3_di", DW'(SRAM_DI[95:64]), DW'(32'hDEADBEEF));
    chk("t3_a", DW'(SRAM_A), DW'(12'h003));
    step("t3", 1'b1, 1'b0);
    drv0(1'b0, '0, '0, '0, 1'b0);
    #1;
    chk("t3_rv0", DW'(c0_rvalid), '0);
    drv0(1'b1, '0, 12'h003, '0, 1'b0);
    step("t3_rd", 1'b1, 1'b0);
    drv0(1'b0, '0, '0, '0, 1'b0);
    step("t3_end", 1'b0, 1'b0);

    j = 0;
    drv0(1'b1, '0, 12'h100, '0, 1'b1);
    for (int c = 0; c < 21; c++) begin
      if (c == 1) drv1(1'b1, '0, 12'h040, '0, 1'b0);
      c0_lock = (j != 19);
      c0_addr = AW'(12'h100 + j);
      step($sformatf("t4_%0d", c), c != 16, c == 16);
      if (c != 16) j++;
      else drv1(1'b0, '0, '0, '0, 1'b0);
    end
    drv0(1'b1, '0, 12'h200, '0, 1'b0);
    drv1(1'b1, '0, 12'h041, '0, 1'b0);
    step("t4_free", 1'b0, 1'b1);
    drv1(1'b0, '0, '0, '0, 1'b0);
    step("t4_c0", 1'b1, 1'b0);
    drv0(1'b0, '0, '0, '0, 1'b0);
    step("t4_end", 1'b0, 1'b0);

    drv1(1'b1, '0, 12'h050, '0, 1'b1);
    drv0(1'b1, '0, 12'h060, '0, 1'b0);
    step("t5_0", 1'b0, 1'b1);
    c1_addr = 12'h051;
    step("t5_1", 1'b0, 1'b1);
    c1_addr = 12'h052;
    step("t5_2", 1'b0, 1'b1);
    drv1(1'b0, '0, '0, '0, 1'b0);
    step("t5_3", 1'b0, 1'b0);
    step("t5_4", 1'b1, 1'b0);
    drv0(1'b0, '0, '0, '0, 1'b0);
    step("t5_end", 1'b0, 1'b0);

    drv1(1'b1, '0, 12'h070, '0, 1'b0);
    drv0(1'b1, '0, 12'h071, '0, 1'b0);
    #1;
    chk("t6_g1", DW'(c1_gnt), DW'(1'b1));
    chk("t6_g0", DW'(c0_gnt), '0);
    q1.push_back(shadow[12'h070]);
    @(posedge CLK);
    #2;
    RSTn = 1'b0;
    q1.delete();
    #1;
    chk("t6_rv1", DW'(c1_rvalid), '0);
    chk("t6_rst_g", DW'({c0_gnt, c1_gnt}), '0);
    chk("t6_rst_web", DW'(SRAM_WEB), DW'(4'hF));
    @(negedge CLK);
    @(negedge CLK);
    drv1(1'b0, '0, '0, '0, 1'b0);
    RSTn = 1'b1;
    step("t6_after", 1'b1, 1'b0);
    drv0(1'b0, '0, '0, '0, 1'b0);
    step("t6_end", 1'b0, 1'b0);
    step("t6_drain", 1'b0, 1'b0);

    chk("q0_empty", DW'(q0.size()), '0);
    chk("q1_empty", DW'(q1.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
